sodor_commit_checker: RTL and testbench
=======================================

# sodor_commit_checker

Elastic lockstep checker that compares the architectural commit stream of a Sodor core against its ISA model. Model commit records are buffered in a parametrised FIFO, so the core may retire each instruction a variable number of cycles after the model, up to DEPTH cycles later. This supports multi-stage Sodor variants, whose retirement timing differs from the single-cycle model. The checker sits in the formal/simulation harness next to the core and model. It raises a sticky, registered failure with a diagnostic capture in place of a fixed-cycle PC/regfile equality check.

## Interface
- XLEN, 32: data/PC width.
- DEPTH, 8: model-record FIFO depth; power of two, ≥2.
- WARMUP, 4: cycles after reset release during which all records are dropped.
- CNT_W, 16: pass counter width.

- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  checking enabled.
- mdl_valid  in  1  model commit record valid.
- mdl_pc  in  XLEN  model retired PC.
- mdl_wen  in  1  model register write.
- mdl_rd  in  5  model destination.
- mdl_wdata  in  XLEN  model write data.
- dut_valid, dut_pc, dut_wen, dut_rd, dut_wdata  in  1/XLEN/1/5/XLEN  core commit record, same meaning.
- pass_cnt  out  CNT_W  matched records, saturating.
- fail  out  1  sticky mismatch flag.
- fail_code  out  3  0 none, 1 PC, 2 writeback, 3 underflow, 4 overflow.
- fail_pc  out  XLEN  expected PC of failing record (0 for code 4).
- fail_exp, fail_got  out  XLEN  expected/observed value: PC for code 1, wdata for code 2, else 0.
- occupancy  out  $clog2(DEPTH)+1  FIFO entries.
- state  out  2  0 WARM, 1 RUN, 2 FAIL.

## Operation
- States:
  - WARM → RUN after WARMUP cycles.
  - RUN → FAIL on any error.
  - FAIL is absorbing until reset.
- WARM: valids ignored; FIFO empty.
- RUN, enable=1:
  - mdl_valid pushes the record.
  - dut_valid pops the head and compares against it.
- Bypass: if the FIFO is empty and both valids are high, the DUT record is compared directly against the incoming model record. Nothing is pushed.
- Simultaneous push and pop with a non-empty FIFO: both occur; occupancy is unchanged. This holds even when full, so no overflow is raised.
- Record match rule:
  - pc equal, and wen equal, and
  - if wen=1 and rd≠0: rd and wdata equal.
  - Writes to x0, and rd/wdata when wen=0, are ignored.
- Error priority: PC (1) > writeback (2). A rd mismatch reports as code 2 with fail_exp/got = wdata.
- Underflow (3): dut_valid with FIFO empty and mdl_valid=0.
- Overflow (4): mdl_valid with FIFO full and dut_valid=0.
- enable=0 in RUN:
  - FIFO flushed; records dropped.
  - Counters held; state stays RUN.
- FAIL:
  - FIFO, pass_cnt and the capture registers are frozen.
  - Inputs are ignored.
  - Only the first failure is captured.
- pass_cnt saturates at all-ones.

## Timing
- Reset (async assert, synchronous-release usage assumed by the harness): every output is 0; state=WARM; FIFO empty; warmup counter 0.
- Reset while in any state: clears immediately; WARMUP restarts on release.
- WARM lasts exactly WARMUP rising edges after reset_n rises. Records presented on those edges are dropped.
- All outputs are registered, one-cycle latency:
  - Comparison at edge N → pass_cnt/fail/fail_* visible after edge N.
  - Push/pop at edge N → occupancy updated after edge N.
- Maximum tolerated DUT lag: DEPTH outstanding records.

## Structure
- Package sodor_verif_pkg:
  - commit_rec_t struct {pc, wen, rd, wdata}.
  - fail_code_e enum.
  - state_e enum.
- Sub-module sodor_commit_fifo: synchronous FIFO of commit_rec_t with DEPTH, flush, full/empty, count. Uses wrap-around pointers with one extra bit for full/empty disambiguation.
- Top level holds the FSM, warmup counter, bypass/compare logic, counters and the capture registers.

## Test plan
- Lag 0: after warmup, 3 cycles with both valid, pc=0x0/0x4/0x8, rd=1, wdata=5 → pass_cnt=3, fail=0, occupancy=0 throughout.
- Lag 3: model pushes pc 0x0,0x4,0x8 on cycles 0–2; core presents the same records on cycles 3–5 → occupancy peaks at 3 then returns to 0; pass_cnt=3.
- PC mismatch: mdl pc=0x8, dut pc=0xC → next cycle fail=1, fail_code=1, fail_pc=0x8, fail_exp=0x8, fail_got=0xC, state=FAIL. Further records leave pass_cnt unchanged.
- x0 write: both wen=1, rd=0, wdata 0x11 vs 0x22 → match, pass_cnt+1. Same records with rd=3 → fail_code=2, fail_exp=0x11, fail_got=0x22.
- DEPTH=8: 9 model pushes with no core commits → fail_code=4 after the 9th edge, occupancy=8. A core commit with an empty FIFO in a fresh run → fail_code=3.
- Reset asserted while in FAIL → all outputs 0 immediately. Records during the following 4 cycles are dropped: no pass_cnt change, no underflow.

Source files
------------

// File: rtl/sodor_verif_pkg.sv
// Shared types and the record comparison rule for the Sodor commit-stream checker.
package sodor_verif_pkg;

  localparam int REC_XLEN = 32;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic                wen;
    logic [4:0]          rd;
    logic [REC_XLEN-1:0] wdata;
  } commit_rec_t;

  typedef enum logic [2:0] {
    FC_NONE  = 3'd0,
    FC_PC    = 3'd1,
    FC_WB    = 3'd2,
    FC_UNDER = 3'd3,
    FC_OVER  = 3'd4
  } fail_code_e;

  typedef enum logic [1:0] {
    ST_WARM = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // PC outranks writeback; rd/wdata only matter for real writes to x1..x31.
  function automatic fail_code_e compare_rec(input commit_rec_t exp_rec,
                                             input commit_rec_t got_rec);
    fail_code_e code;
    code = FC_NONE;
    if (exp_rec.pc != got_rec.pc) begin
      code = FC_PC;
    end else if (exp_rec.wen != got_rec.wen) begin
      code = FC_WB;
    end else if (exp_rec.wen && (exp_rec.rd != 5'd0) &&
                 ((exp_rec.rd != got_rec.rd) || (exp_rec.wdata != got_rec.wdata))) begin
      code = FC_WB;
    end
    return code;
  endfunction

endpackage

// File: rtl/sodor_commit_fifo.sv
// Synchronous FIFO of model commit records with flush; pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.
module sodor_commit_fifo
  import sodor_verif_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  commit_rec_t             wr_rec_i,
  output commit_rec_t             rd_rec_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  commit_rec_t mem_q [DEPTH];

  assign rd_rec_o = mem_q[rptr_q[AW-1:0]];
  assign count_o  = wptr_q - rptr_q;
  assign empty_o  = (wptr_q == rptr_q);
  assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + (AW+1)'(1);
      if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  // A push into a full FIFO only happens alongside a pop, so it overwrites the
  // head slot that is being read out on the same edge.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wptr_q[AW-1:0]] <= wr_rec_i;
    end
  end

endmodule

// File: rtl/sodor_commit_checker.sv
// Elastic lockstep checker: buffers model commits and compares them against the
// core's later retirements, latching the first mismatch with a diagnostic capture.
module sodor_commit_checker
  import sodor_verif_pkg::*;
#(
  parameter int XLEN   = REC_XLEN,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    mdl_valid,
  input  logic [XLEN-1:0]         mdl_pc,
  input  logic                    mdl_wen,
  input  logic [4:0]              mdl_rd,
  input  logic [XLEN-1:0]         mdl_wdata,
  input  logic                    dut_valid,
  input  logic [XLEN-1:0]         dut_pc,
  input  logic                    dut_wen,
  input  logic [4:0]              dut_rd,
  input  logic [XLEN-1:0]         dut_wdata,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic                    fail,
  output logic [2:0]              fail_code,
  output logic [XLEN-1:0]         fail_pc,
  output logic [XLEN-1:0]         fail_exp,
  output logic [XLEN-1:0]         fail_got,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [1:0]              state
);

  localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP - 1);

  state_e            state_q;
  logic [WCNT_W-1:0] warm_cnt_q;
  logic [CNT_W-1:0]  pass_cnt_q;
  logic              fail_q;
  fail_code_e        fail_code_q;
  logic [XLEN-1:0]   fail_pc_q, fail_exp_q, fail_got_q;

  commit_rec_t mdl_rec, dut_rec, head_rec, exp_rec;
  logic        fifo_full, fifo_empty;
  logic        push, pop, flush, compare;
  fail_code_e  err_code;

  assign mdl_rec = '{pc: mdl_pc, wen: mdl_wen, rd: mdl_rd, wdata: mdl_wdata};
  assign dut_rec = '{pc: dut_pc, wen: dut_wen, rd: dut_rd, wdata: dut_wdata};

  sodor_commit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (flush),
    .push_i   (push),
    .pop_i    (pop),
    .wr_rec_i (mdl_rec),
    .rd_rec_o (head_rec),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (occupancy)
  );

  // Decide this edge's FIFO traffic and comparison. With an empty FIFO and both
  // sides valid the core record is checked straight against the incoming one.
  // Any error freezes the FIFO on the very edge it is detected.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    compare  = 1'b0;
    err_code = FC_NONE;
    exp_rec  = head_rec;
    if (state_q == ST_RUN) begin
      if (!enable) begin
        flush = 1'b1;
      end else if (fifo_empty) begin
        if (mdl_valid && dut_valid) begin
          compare = 1'b1;
          exp_rec = mdl_rec;
        end else if (dut_valid) begin
          err_code = FC_UNDER;
        end else if (mdl_valid) begin
          push = 1'b1;
        end
      end else begin
        if (dut_valid) begin
          compare = 1'b1;
          pop     = 1'b1;
          push    = mdl_valid;
        end else if (mdl_valid) begin
          if (fifo_full) err_code = FC_OVER;
          else           push     = 1'b1;
        end
      end
      if (compare) err_code = compare_rec(exp_rec, dut_rec);
      if (err_code != FC_NONE) begin
        push = 1'b0;
        pop  = 1'b0;
      end
    end
  end

  // Checker FSM with warmup counter, saturating pass counter and first-failure capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WARM;
      warm_cnt_q  <= '0;
      pass_cnt_q  <= '0;
      fail_q      <= 1'b0;
      fail_code_q <= FC_NONE;
      fail_pc_q   <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      case (state_q)
        ST_WARM: begin
          if (warm_cnt_q == WARM_LAST) state_q    <= ST_RUN;
          else                         warm_cnt_q <= warm_cnt_q + WCNT_W'(1);
        end
        ST_RUN: begin
          if (err_code != FC_NONE) begin
            state_q     <= ST_FAIL;
            fail_q      <= 1'b1;
            fail_code_q <= err_code;
            if (err_code == FC_PC) begin
              fail_pc_q  <= exp_rec.pc;
              fail_exp_q <= exp_rec.pc;
              fail_got_q <= dut_rec.pc;
            end else if (err_code == FC_WB) begin
              fail_pc_q  <= exp_rec.pc;
              fail_exp_q <= exp_rec.wdata;
              fail_got_q <= dut_rec.wdata;
            end
          end else if (compare && (pass_cnt_q != '1)) begin
            pass_cnt_q <= pass_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign pass_cnt  = pass_cnt_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign fail_pc   = fail_pc_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sodor_commit_checker.sv
// Self-checking bench for sodor_commit_checker: directed scenarios plus a
// randomized run scored against a queue-based reference model.
module tb_sodor_commit_checker;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 8;
  localparam int WARMUP   = 4;
  localparam int CNT_W    = 5;
  localparam int PASS_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             mdl_valid = 1'b0, mdl_wen = 1'b0, dut_valid = 1'b0, dut_wen = 1'b0;
  logic [XLEN-1:0]  mdl_pc = '0, mdl_wdata = '0, dut_pc = '0, dut_wdata = '0;
  logic [4:0]       mdl_rd = '0, dut_rd = '0;
  logic [CNT_W-1:0] pass_cnt;
  logic             fail;
  logic [2:0]       fail_code;
  logic [XLEN-1:0]  fail_pc, fail_exp, fail_got;
  logic [3:0]       occupancy;
  logic [1:0]       state;

  sodor_commit_checker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .WARMUP(WARMUP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .mdl_valid(mdl_valid), .mdl_pc(mdl_pc), .mdl_wen(mdl_wen), .mdl_rd(mdl_rd), .mdl_wdata(mdl_wdata),
    .dut_valid(dut_valid), .dut_pc(dut_pc), .dut_wen(dut_wen), .dut_rd(dut_rd), .dut_wdata(dut_wdata),
    .pass_cnt(pass_cnt), .fail(fail), .fail_code(fail_code), .fail_pc(fail_pc),
    .fail_exp(fail_exp), .fail_got(fail_got), .occupancy(occupancy), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } rec_t;

  // Reference model: pending model records, phase (0 warm, 1 run, 2 fail), counters, capture.
  rec_t        mq[$];
  int          m_state, m_warm, m_pass, m_code;
  logic [31:0] m_fpc, m_fexp, m_fgot;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic int rec_code(input rec_t e, input rec_t g);
    if (e.pc !== g.pc) return 1;
    if (e.wen !== g.wen) return 2;
    if (e.wen && e.rd != 0 && (e.rd != g.rd || e.wdata != g.wdata)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_warm = 0; m_pass = 0; m_code = 0;
    m_fpc = '0; m_fexp = '0; m_fgot = '0;
  endtask

  task automatic model_edge();
    rec_t e, g, m;
    int   code;
    bit   cmp, bypass;
    m = '{mdl_pc, mdl_wen, mdl_rd, mdl_wdata};
    g = '{dut_pc, dut_wen, dut_rd, dut_wdata};
    e = m;
    if (!reset_n) return;
    if (m_state == 0) begin
      m_warm++;
      if (m_warm >= WARMUP) m_state = 1;
    end else if (m_state == 1) begin
      if (!enable) begin
        mq.delete();
      end else begin
        code = 0; cmp = 0;
        bypass = mdl_valid && dut_valid && (mq.size() == 0);
        if (dut_valid) begin
          if (mq.size() > 0) begin e = mq[0]; cmp = 1; end
          else if (mdl_valid) begin e = m; cmp = 1; end
          else code = 3;
        end else if (mdl_valid && mq.size() == DEPTH) begin
          code = 4;
        end
        if (cmp) code = rec_code(e, g);
        if (code != 0) begin
          m_state = 2; m_code = code;
          if (code == 1) begin m_fpc = e.pc; m_fexp = e.pc; m_fgot = g.pc; end
          if (code == 2) begin m_fpc = e.pc; m_fexp = e.wdata; m_fgot = g.wdata; end
        end else begin
          if (cmp && m_pass < PASS_MAX) m_pass++;
          if (dut_valid && !bypass) void'(mq.pop_front());
          if (mdl_valid && !bypass) mq.push_back(m);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    enable = 1'b1; mdl_valid = 1'b0; dut_valid = 1'b0;
  endtask

  task automatic drive(input bit mv, input logic [31:0] mpc, input bit mw, input logic [4:0] mrd,
                       input logic [31:0] mwd, input bit dv, input logic [31:0] dpc, input bit dw,
                       input logic [4:0] drd, input logic [31:0] dwd);
    enable = 1'b1;
    mdl_valid = mv; mdl_pc = mpc; mdl_wen = mw; mdl_rd = mrd; mdl_wdata = mwd;
    dut_valid = dv; dut_pc = dpc; dut_wen = dw; dut_rd = drd; dut_wdata = dwd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic reset_and_warm();
    do_reset();
    repeat (WARMUP) tick();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (pass_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_pass_cnt got %0d want 0", pass_cnt); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fail got %0b want 0", fail); end
    n_checks++; if (fail_code !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_fail_code got %0d want 0", fail_code); end
    n_checks++; if ({fail_pc, fail_exp, fail_got} !== '0) begin n_fail++; $display("[TB] FAIL reset_capture got %h/%h/%h want 0", fail_pc, fail_exp, fail_got); end
    n_checks++; if (occupancy !== '0) begin n_fail++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_state got %0d want 0", state); end
  endtask

  task automatic test_warmup();
    do_reset();
    for (int i = 1; i <= WARMUP; i++) begin
      drive(i[0], 32'h40, 1'b1, 5'd2, 32'h1, 1'b1, 32'h80, 1'b1, 5'd2, 32'h2);
      tick();
      n_checks++; if (state !== ((i == WARMUP) ? 2'd1 : 2'd0)) begin n_fail++; $display("[TB] FAIL warmup_state edge %0d got %0d want %0d", i, state, (i == WARMUP) ? 1 : 0); end
      n_checks++; if ({fail, occupancy, pass_cnt} !== '0) begin n_fail++; $display("[TB] FAIL warmup_drop edge %0d got fail=%0b occ=%0d pass=%0d want 0", i, fail, occupancy, pass_cnt); end
    end
  endtask

  task automatic test_lag0();
    reset_and_warm();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(4 * i), 1, 5'd1, 32'd5, 1, 32'(4 * i), 1, 5'd1, 32'd5);
      tick();
      n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL lag0_occupancy cycle %0d got %0d want 0", i, occupancy); end
    end
    n_checks++; if (pass_cnt !== 5'd3) begin n_fail++; $display("[TB] FAIL lag0_pass_cnt got %0d want 3", pass_cnt); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("[TB] FAIL lag0_fail got %0b want 0", fail); end
  endtask

  task automatic test_lag3();
    int exp_occ[6] = '{1, 2, 3, 2, 1, 0};
    reset_and_warm();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1, 32'(4 * i), 1, 5'd1, 32'd5, 0, 32'd0, 0, 5'd0, 32'd0);
      else       drive(0, 32'd0, 0, 5'd0, 32'd0, 1, 32'(4 * (i - 3)), 1, 5'd1, 32'd5);
      tick();
      n_checks++; if (occupancy !== 4'(exp_occ[i])) begin n_fail++; $display("[TB] FAIL lag3_occupancy cycle %0d got %0d want %0d", i, occupancy, exp_occ[i]); end
    end
    n_checks++; if (pass_cnt !== 5'd3 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL lag3_result got pass=%0d fail=%0b want pass=3 fail=0", pass_cnt, fail); end
  endtask

  task automatic test_pc_mismatch();
    reset_and_warm();
    drive(1, 32'h8, 1, 5'd1, 32'd5, 1, 32'hC, 1, 5'd1, 32'd5);
    tick();
    n_checks++; if (fail !== 1'b1 || fail_code !== 3'd1) begin n_fail++; $display("[TB] FAIL pcmis_code got fail=%0b code=%0d want 1/1", fail, fail_code); end
    n_checks++; if (fail_pc !== 32'h8 || fail_exp !== 32'h8 || fail_got !== 32'hC) begin n_fail++; $display("[TB] FAIL pcmis_capture got %h/%h/%h want 8/8/c", fail_pc, fail_exp, fail_got); end
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("[TB] FAIL pcmis_state got %0d want 2", state); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h10, 1, 5'd1, 32'd5, 1, 32'h10, 1, 5'd1, 32'd5);
      tick();
    end
    n_checks++; if (pass_cnt !== 5'd0 || fail_code !== 3'd1 || fail_got !== 32'hC) begin n_fail++; $display("[TB] FAIL pcmis_frozen got pass=%0d code=%0d got=%h want 0/1/c", pass_cnt, fail_code, fail_got); end
  endtask

  task automatic test_x0_write();
    reset_and_warm();
    drive(1, 32'h20, 1, 5'd0, 32'h11, 1, 32'h20, 1, 5'd0, 32'h22);
    tick();
    n_checks++; if (pass_cnt !== 5'd1 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_match got pass=%0d fail=%0b want 1/0", pass_cnt, fail); end
    drive(1, 32'h24, 0, 5'd7, 32'h33, 1, 32'h24, 0, 5'd9, 32'h44);
    tick();
    n_checks++; if (pass_cnt !== 5'd2 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL nowrite_match got pass=%0d fail=%0b want 2/0", pass_cnt, fail); end
    drive(1, 32'h28, 1, 5'd3, 32'h11, 1, 32'h28, 1, 5'd3, 32'h22);
    tick();
    n_checks++; if (fail_code !== 3'd2 || fail_exp !== 32'h11 || fail_got !== 32'h22 || fail_pc !== 32'h28) begin n_fail++; $display("[TB] FAIL wb_mismatch got code=%0d pc=%h exp=%h got=%h want 2/28/11/22", fail_code, fail_pc, fail_exp, fail_got); end
  endtask

  task automatic test_overflow_underflow();
    reset_and_warm();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 32'(4 * i), 1, 5'd1, 32'd5, 0, 32'd0, 0, 5'd0, 32'd0);
      tick();
      if (i == DEPTH - 1) begin
        n_checks++; if (occupancy !== 4'd8 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_full got occ=%0d fail=%0b want 8/0", occupancy, fail); end
      end
    end
    n_checks++; if (fail_code !== 3'd4 || occupancy !== 4'd8 || fail_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL overflow got code=%0d occ=%0d pc=%h want 4/8/0", fail_code, occupancy, fail_pc); end
    reset_and_warm();
    drive(0, 32'd0, 0, 5'd0, 32'd0, 1, 32'h4, 1, 5'd1, 32'd5);
    tick();
    n_checks++; if (fail_code !== 3'd3 || state !== 2'd2) begin n_fail++; $display("[TB] FAIL underflow got code=%0d state=%0d want 3/2", fail_code, state); end
  endtask

  task automatic test_full_pushpop();
    reset_and_warm();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'(4 * i), 1, 5'd2, 32'(i), 0, 32'd0, 0, 5'd0, 32'd0);
      tick();
    end
    drive(1, 32'h100, 1, 5'd2, 32'h9, 1, 32'h0, 1, 5'd2, 32'h0);
    tick();
    n_checks++; if (occupancy !== 4'd8 || fail !== 1'b0 || pass_cnt !== 5'd1) begin n_fail++; $display("[TB] FAIL full_pushpop got occ=%0d fail=%0b pass=%0d want 8/0/1", occupancy, fail, pass_cnt); end
  endtask

  task automatic test_enable_flush();
    reset_and_warm();
    drive(1, 32'h0, 1, 5'd1, 32'd1, 1, 32'h0, 1, 5'd1, 32'd1);
    tick();
    drive(1, 32'h4, 1, 5'd1, 32'd2, 0, 32'd0, 0, 5'd0, 32'd0);
    tick();
    tick();
    drive(1, 32'h8, 1, 5'd1, 32'd3, 1, 32'hBAD, 1, 5'd1, 32'd3);
    enable = 1'b0;
    tick();
    n_checks++; if (occupancy !== 4'd0 || state !== 2'd1 || pass_cnt !== 5'd1 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL disable_flush got occ=%0d state=%0d pass=%0d fail=%0b want 0/1/1/0", occupancy, state, pass_cnt, fail); end
    drive(0, 32'd0, 0, 5'd0, 32'd0, 1, 32'h4, 1, 5'd1, 32'd2);
    tick();
    n_checks++; if (fail_code !== 3'd3) begin n_fail++; $display("[TB] FAIL flushed_underflow got code=%0d want 3", fail_code); end
  endtask

  task automatic test_saturation();
    reset_and_warm();
    for (int i = 0; i < PASS_MAX + 4; i++) begin
      drive(1, 32'(4 * i), 1, 5'd4, 32'(i), 1, 32'(4 * i), 1, 5'd4, 32'(i));
      tick();
    end
    n_checks++; if (pass_cnt !== 5'd31 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL saturate got pass=%0d fail=%0b want 31/0", pass_cnt, fail); end
  endtask

  task automatic test_reset_in_fail();
    reset_and_warm();
    drive(1, 32'h8, 1, 5'd1, 32'd5, 1, 32'hC, 1, 5'd1, 32'd5);
    tick();
    idle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if ({pass_cnt, fail, fail_code, fail_pc, fail_exp, fail_got, occupancy, state} !== '0) begin n_fail++; $display("[TB] FAIL reset_in_fail got pass=%0d fail=%0b code=%0d occ=%0d state=%0d want all 0", pass_cnt, fail, fail_code, occupancy, state); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < WARMUP; i++) begin
      drive(i[0], 32'h4, 1, 5'd1, 32'd5, 1, 32'h4, 1, 5'd1, 32'd5);
      tick();
      n_checks++; if (pass_cnt !== '0 || fail !== 1'b0 || occupancy !== '0) begin n_fail++; $display("[TB] FAIL rewarm_drop cycle %0d got pass=%0d fail=%0b occ=%0d want 0", i, pass_cnt, fail, occupancy); end
    end
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("[TB] FAIL rewarm_state got %0d want 1", state); end
  endtask

  task automatic test_random();
    int   fail_hold = 0;
    rec_t m, g;
    bit   mv, dv;
    int   r;
    reset_and_warm();
    for (int c = 0; c < 4000; c++) begin
      m.pc = $urandom & 32'hFFFF_FFFC; m.wen = 1'($urandom_range(0, 1));
      m.rd = 5'($urandom_range(0, 31)); m.wdata = $urandom;
      mv = ($urandom_range(0, 99) < 48);
      if (mq.size() > 0) dv = ($urandom_range(0, 99) < 48);
      else               dv = mv ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 2);
      g = (mq.size() > 0) ? mq[0] : m;
      if (!g.wen) begin g.rd = 5'($urandom_range(0, 31)); g.wdata = $urandom; end
      if (g.wen && g.rd == 0) g.wdata = $urandom;
      r = $urandom_range(0, 199);
      if (r < 2) g.pc = g.pc ^ 32'h4;
      else if (r < 4) g.wdata = g.wdata ^ (32'h1 << $urandom_range(0, 31));
      else if (r < 5) g.rd = g.rd ^ 5'h1;
      else if (r < 6) g.wen = ~g.wen;
      drive(mv, m.pc, m.wen, m.rd, m.wdata, dv, g.pc, g.wen, g.rd, g.wdata);
      enable = ($urandom_range(0, 39) != 0);
      tick();
      n_checks++; if (pass_cnt !== CNT_W'(m_pass)) begin n_fail++; $display("[TB] FAIL rand_pass_cnt cycle %0d got %0d want %0d", c, pass_cnt, m_pass); end
      n_checks++; if (fail !== (m_state == 2)) begin n_fail++; $display("[TB] FAIL rand_fail cycle %0d got %0b want %0b", c, fail, m_state == 2); end
      n_checks++; if (fail_code !== 3'(m_code)) begin n_fail++; $display("[TB] FAIL rand_fail_code cycle %0d got %0d want %0d", c, fail_code, m_code); end
      n_checks++; if (fail_pc !== m_fpc) begin n_fail++; $display("[TB] FAIL rand_fail_pc cycle %0d got %h want %h", c, fail_pc, m_fpc); end
      n_checks++; if (fail_exp !== m_fexp || fail_got !== m_fgot) begin n_fail++; $display("[TB] FAIL rand_exp_got cycle %0d got %h/%h want %h/%h", c, fail_exp, fail_got, m_fexp, m_fgot); end
      n_checks++; if (occupancy !== 4'(mq.size())) begin n_fail++; $display("[TB] FAIL rand_occupancy cycle %0d got %0d want %0d", c, occupancy, mq.size()); end
      n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("[TB] FAIL rand_state cycle %0d got %0d want %0d", c, state, m_state); end
      if (m_state == 2) begin
        fail_hold++;
        if (fail_hold >= 3) begin
          fail_hold = 0;
          reset_and_warm();
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_warmup();
    test_lag0();
    test_lag3();
    test_pc_mismatch();
    test_x0_write();
    test_overflow_underflow();
    test_full_pushpop();
    test_enable_flush();
    test_saturation();
    test_reset_in_fail();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
